// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: funct/alu_op codes,
// the internal operation enum, the FSM state type and the decode helper.
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_MFHI, OP_MFLO, OP_MUL, OP_DIV, OP_ILLEGAL
  } alu_opc_e;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_e;

  // HI/LO-related functs fall back to illegal when the mul/div engine is absent.
  function automatic alu_opc_e decode_op(input logic [1:0] alu_op, input logic [5:0] funct,
                                         input logic muldiv_en);
    alu_opc_e op;
    op = OP_ILLEGAL;
    if (alu_op == ALUOP_ADD) op = OP_ADD;
    else if (alu_op == ALUOP_SUB) op = OP_SUB;
    else begin
      case (funct)
        F_ADD:  op = OP_ADD;
        F_SUB:  op = OP_SUB;
        F_AND:  op = OP_AND;
        F_OR:   op = OP_OR;
        F_XOR:  op = OP_XOR;
        F_NOR:  op = OP_NOR;
        F_SLT:  op = OP_SLT;
        F_SLTU: op = OP_SLTU;
        F_MFHI: if (muldiv_en) op = OP_MFHI;
        F_MFLO: if (muldiv_en) op = OP_MFLO;
        F_MULT, F_MULTU: if (muldiv_en) op = OP_MUL;
        F_DIV,  F_DIVU:  if (muldiv_en) op = OP_DIV;
        default: op = OP_ILLEGAL;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/alu_exec_unit_muldiv.sv
// Iterative multiply (shift-add) / divide (restoring) engine on operand magnitudes.
// The final step and sign fix-up are combinational so the caller can latch hi/lo on o_last.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_last
);

  logic             r_run, r_div, r_neg_q, r_neg_r;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_opnd;

  logic             w_a_neg, w_b_neg, w_ge;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_diff, w_hi_nx, w_lo_nx;
  logic [WIDTH:0]   w_sum, w_rs;
  logic [2*WIDTH-1:0] w_prod, w_prod_neg;

  assign w_a_neg = i_signed & i_a[WIDTH-1];
  assign w_b_neg = i_signed & i_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;

  assign w_sum  = {1'b0, r_hi} + {1'b0, r_opnd};
  assign w_rs   = {r_hi, r_lo[WIDTH-1]};
  assign w_ge   = (w_rs >= {1'b0, r_opnd});
  // Remainder stays below the divisor, so the low WIDTH bits of the difference are exact.
  assign w_diff = w_rs[WIDTH-1:0] - r_opnd;

  always_comb begin
    w_hi_nx = r_hi;
    w_lo_nx = r_lo;
    if (r_div) begin
      w_hi_nx = w_ge ? w_diff : w_rs[WIDTH-1:0];
      w_lo_nx = {r_lo[WIDTH-2:0], w_ge};
    end else if (r_lo[0]) begin
      {w_hi_nx, w_lo_nx} = {w_sum, r_lo[WIDTH-1:1]};
    end else begin
      {w_hi_nx, w_lo_nx} = {1'b0, r_hi, r_lo[WIDTH-1:1]};
    end
  end

  assign w_prod     = {w_hi_nx, w_lo_nx};
  assign w_prod_neg = -w_prod;

  always_comb begin
    if (r_div) begin
      o_lo = r_neg_q ? -w_lo_nx : w_lo_nx;
      o_hi = r_neg_r ? -w_hi_nx : w_hi_nx;
    end else begin
      {o_hi, o_lo} = r_neg_q ? w_prod_neg : w_prod;
    end
  end

  assign o_last = r_run && (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run   <= 1'b0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opnd  <= '0;
    end else if (i_start) begin
      r_run   <= 1'b1;
      r_div   <= i_is_div;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_cnt   <= '0;
      r_hi    <= '0;
      // mul: lo holds the multiplier, opnd the multiplicand; div: lo holds the dividend.
      r_lo    <= i_is_div ? w_a_mag : w_b_mag;
      r_opnd  <= i_is_div ? w_b_mag : w_a_mag;
    end else if (r_run) begin
      r_hi  <= w_hi_nx;
      r_lo  <= w_lo_nx;
      r_cnt <= r_cnt + CNT_W'(1);
      if (o_last) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: funct decode, registered single-cycle ALU, start/done FSM and HI/LO.
// Define ALU_MULDIV_EN to include the iterative mult/div engine and HI/LO registers.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

`ifdef ALU_MULDIV_EN
  localparam logic MULDIV_EN = 1'b1;
`else
  localparam logic MULDIV_EN = 1'b0;
`endif

  alu_opc_e         w_op;
  state_e           r_state, w_state_nx;
  logic [WIDTH-1:0] r_result, w_alu_res, w_hi, w_lo;
  logic             r_zero, r_illegal, w_accept, w_muldiv, w_last;

  assign w_op     = decode_op(alu_op, funct, MULDIV_EN);
  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_muldiv = (w_op == OP_MUL) || (w_op == OP_DIV);

  always_comb begin
    w_alu_res = '0;
    case (w_op)
      OP_ADD:  w_alu_res = a + b;
      OP_SUB:  w_alu_res = a - b;
      OP_AND:  w_alu_res = a & b;
      OP_OR:   w_alu_res = a | b;
      OP_XOR:  w_alu_res = a ^ b;
      OP_NOR:  w_alu_res = ~(a | b);
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MFHI: w_alu_res = w_hi;
      OP_MFLO: w_alu_res = w_lo;
      default: w_alu_res = '0;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (w_op == OP_MUL)      w_state_nx = ST_MUL;
          else if (w_op == OP_DIV) w_state_nx = ST_DIV;
          else                     w_state_nx = ST_DONE;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: if (w_last) w_state_nx = ST_DONE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  // Multicycle ops leave result/zero alone; software fetches them via mfhi/mflo.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      if (w_accept && !w_muldiv) begin
        r_result  <= w_alu_res;
        r_zero    <= (w_alu_res == '0);
        r_illegal <= (w_op == OP_ILLEGAL);
      end
    end
  end

`ifdef ALU_MULDIV_EN
  logic [WIDTH-1:0] r_hi, r_lo, w_eng_hi, w_eng_lo;

  muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_accept && w_muldiv),
    .i_signed(~funct[0]),
    .i_is_div(w_op == OP_DIV),
    .i_a     (a),
    .i_b     (b),
    .o_hi    (w_eng_hi),
    .o_lo    (w_eng_lo),
    .o_last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (((r_state == ST_MUL) || (r_state == ST_DIV)) && w_last) begin
      r_hi <= w_eng_hi;
      r_lo <= w_eng_lo;
    end
  end

  assign w_hi = r_hi;
  assign w_lo = r_lo;
  assign busy = (r_state == ST_MUL) || (r_state == ST_DIV);
`else
  assign w_last = 1'b0;
  assign w_hi   = '0;
  assign w_lo   = '0;
  assign busy   = 1'b0;
`endif

  assign done    = (r_state == ST_DONE);
  assign result  = r_result;
  assign zero    = r_zero;
  assign illegal = r_illegal;
  assign hi      = w_hi;
  assign lo      = w_lo;

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised successor to the combinational ALU decoder. It merges ALUop/funct decoding with a registered execution stage and an iterative multiply/divide engine that owns HI/LO. It sits in the multicycle datapath's EX step. The controller issues an operation with a start pulse and waits for a done pulse.

## Interface
- WIDTH, 32: datapath width in bits; must be ≥ 8 and even.
- CNT_W, $clog2(WIDTH)+1: width of the iteration counter.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- alu_op  in  2  00 add, 01 subtract, 1x decode by funct
- funct  in  6  R-type funct field; sampled with start
- a, b  in  WIDTH  operands; sampled with start
- start  in  1  issue request; accepted only when busy=0
- busy  out  1  multicycle operation in progress
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  registered result; held until the next completion
- zero  out  1  result == 0; registered together with result
- illegal  out  1  unsupported funct; valid with done
- hi, lo  out  WIDTH  architectural HI/LO registers

## Operation
- Decode uses the full 6-bit funct, with no don't-care bits.
  - Single-cycle functs: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt (signed), 101011 sltu, 010000 mfhi, 010010 mflo.
  - Multicycle functs: 011000 mult, 011001 multu, 011010 div, 011011 divu.
  - Any other funct with alu_op=1x is illegal.
- alu_op 00 and 01 ignore funct.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE or DONE, start=1, single-cycle or illegal op → DONE. result and zero are written; illegal forces result=0.
  - IDLE or DONE, start=1, mult/multu → MUL. div/divu → DIV. Operand magnitudes are latched (signed forms only) and the counter is set to 0.
  - MUL or DIV: one shift-add or restoring-subtract step per cycle. After WIDTH steps: sign fix-up, hi/lo written, go to DONE.
  - DONE, no start → IDLE.
- Multicycle ops leave result and zero unchanged. Software reads the product or quotient with mfhi/mflo.
- mult/multu: {hi, lo} = full 2·WIDTH-bit product.
- div/divu: lo = quotient, hi = remainder.
  - Signed: quotient is truncated toward zero; remainder takes the sign of the dividend.
  - Divide by zero, no trap: lo = all ones, hi = a (unsigned); signed results follow the same magnitude rule and then the sign fix-up.
- Add and sub wrap modulo 2^WIDTH. No overflow flag.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - result, hi, lo = 0; zero = 1.
  - busy, done, illegal = 0.
- Reset mid-operation aborts the operation. No partial write reaches hi/lo.
- Single-cycle op: start at edge t → done=1 in cycle t+1.
- Multicycle op: start at edge t → busy=1 for cycles t+1 through t+WIDTH → done=1 in cycle t+WIDTH+1, with hi/lo already updated.
- start while busy=1 is ignored: no queueing, no error.
- start in the DONE cycle is accepted, which gives back-to-back issue.
- mfhi/mflo issued in the done cycle of a mult/div returns the new hi/lo.
- done and illegal are single-cycle pulses.

## Configuration
- ALU_MULDIV_EN defined:
  - MUL/DIV states and the iterative engine are present.
  - hi/lo behave as specified.
- ALU_MULDIV_EN undefined:
  - mult, multu, div, divu, mfhi and mflo decode as illegal.
  - hi and lo are tied to 0.
  - busy is constant 0; every accepted op completes in one cycle.

## Structure
- Package alu_pkg holds:
  - funct localparams and alu_op codes;
  - the internal operation enum (add, sub, and, or, xor, nor, slt, sltu, mfhi, mflo, mul, div, illegal);
  - the FSM state typedef.
- Sub-module muldiv_iter holds the iterative engine:
  - start, signed, is_div and operand inputs;
  - hi/lo result outputs and a last-step strobe.
- alu_exec_unit holds the decoder, single-cycle ALU, FSM and HI/LO registers.
- muldiv_iter is instantiated only under ALU_MULDIV_EN.

## Test plan
- alu_op=10, funct=100000, a=5, b=7, start → next cycle done=1, result=12, zero=0, busy never high.
- alu_op=01, a=9, b=9 → result=0, zero=1. Then slt with a=0xFFFFFFFF, b=1 → result=1; sltu with the same operands → result=0.
- mult, a=0xFFFFFFFD (−3), b=7 → done exactly 33 cycles after start, hi=0xFFFFFFFF, lo=0xFFFFFFEB. A start pulse at cycle 10 is ignored; the following mflo returns 0xFFFFFFEB.
- div, a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu, a=5, b=0 → lo=0xFFFFFFFF, hi=5.
- reset asserted at cycle 10 of a mult → next cycle busy=0, done=0, hi=lo=0, state IDLE; a new add then completes normally.
- funct=111111 with alu_op=10 → done=1, illegal=1, result=0. With ALU_MULDIV_EN undefined, funct=011000 gives the same response and hi=lo=0.
